// File: rtl/note_scroll_ctrl_pkg.sv
// Shared constants, row type and FSM state encoding for the note RAM scroll controller.
package note_pkg;

    localparam int ROW_W  = 128;
    localparam int ADDR_W = 5;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_INSERT = 2'd2;
    localparam logic [1:0] ST_CLEAR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SHIFT  = ST_SHIFT,
        INSERT = ST_INSERT,
        CLEAR  = ST_CLEAR
    } state_t;

    typedef logic [ROW_W-1:0] row_t;

endpackage

// File: rtl/note_scroll_ctrl_if.sv
// Note RAM port bundle: the controller drives addresses/data/wren, the RAM returns q.
interface note_scroll_ctrl_if #(
    parameter int AW = note_pkg::ADDR_W,
    parameter int DW = note_pkg::ROW_W
);

    logic [AW-1:0] ram_rdaddress;
    logic [AW-1:0] ram_wraddress;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [DW-1:0] ram_q;

    modport master (
        output ram_rdaddress, ram_wraddress, ram_data, ram_wren,
        input  ram_q
    );

    modport slave (
        input  ram_rdaddress, ram_wraddress, ram_data, ram_wren,
        output ram_q
    );

endinterface

// File: rtl/note_scroll_ctrl.sv
// Per-frame note RAM sequencer: scroll down one row, insert chart row, apply hit clears.
// Optional NOTE_MISS_OUT_EN drives miss_row/miss_valid with the row leaving the bottom.
module note_scroll_ctrl #(
    parameter int ROWS      = 20,
    parameter int ROW_W     = note_pkg::ROW_W,
    parameter int ADDR_W    = note_pkg::ADDR_W,
    parameter int SPEED_DIV = 1
) (
    input  logic                  vgaclk,
    input  logic                  reset_n,
    input  logic                  blank,
    input  logic [ADDR_W-1:0]     pix_rdaddr,
    output logic [ROW_W-1:0]      pix_q,
    input  logic [ROW_W-1:0]      chart_row,
    output logic                  chart_ack,
    input  logic                  clr_valid,
    input  logic [ADDR_W-1:0]     clr_row,
    input  logic [ROW_W-1:0]      clr_mask,
    output logic                  clr_ready,
    note_scroll_ctrl_if.master    ram,
    output logic [ROW_W-1:0]      miss_row,
    output logic                  miss_valid,
    output logic                  overrun
);

    import note_pkg::*;

    localparam int CW = ADDR_W + 1;

    state_t             r_state;
    logic [CW-1:0]      r_idx;
    logic [3:0]         r_div;
    logic               r_blank_d;
    logic               r_fstart;
    logic               r_overrun;
    logic               r_clr_busy;
    logic               r_clr_skip;
    logic [ADDR_W-1:0]  r_clr_row;
    logic [ROW_W-1:0]   r_clr_mask;

    logic               w_blank_rise;
    logic               w_div_wrap;
    logic [ADDR_W-1:0]  w_rdaddr;
    logic [ADDR_W-1:0]  w_wraddr;
    logic [ROW_W-1:0]   w_wdata;
    logic               w_wren;

    assign w_blank_rise = blank & ~r_blank_d;
    assign w_div_wrap   = (r_div == 4'(SPEED_DIV - 1));

    // SHIFT cycle idx reads row ROWS-1-idx and writes the previous read to row ROWS+1-idx;
    // idx 1 returns the bottom row (miss, not written), idx ROWS is the drain write.
    always_comb begin
        w_rdaddr  = '0;
        w_wraddr  = '0;
        w_wdata   = '0;
        w_wren    = 1'b0;
        clr_ready = 1'b0;
        chart_ack = 1'b0;
        case (r_state)
            IDLE: begin
                w_rdaddr = pix_rdaddr;
            end
            SHIFT: begin
                if (r_idx < CW'(ROWS)) begin
                    w_rdaddr = ADDR_W'(ROWS - 1 - int'(r_idx));
                end
                if (r_idx >= CW'(2)) begin
                    w_wren   = 1'b1;
                    w_wraddr = ADDR_W'(ROWS + 1 - int'(r_idx));
                    w_wdata  = ram.ram_q;
                end
            end
            INSERT: begin
                w_rdaddr  = ADDR_W'(1);
                w_wren    = 1'b1;
                w_wraddr  = '0;
                w_wdata   = chart_row;
                chart_ack = 1'b1;
            end
            CLEAR: begin
                if (r_clr_busy) begin
                    // read address steered off the write row so the port never collides
                    w_rdaddr = r_clr_row ^ ADDR_W'(1);
                    w_wren   = ~r_clr_skip;
                    w_wraddr = r_clr_row;
                    w_wdata  = ram.ram_q & ~r_clr_mask;
                end else begin
                    w_rdaddr  = clr_row;
                    clr_ready = ~blank;
                end
            end
        endcase
    end

    always_ff @(posedge vgaclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_div      <= '0;
            r_blank_d  <= 1'b0;
            r_fstart   <= 1'b0;
            r_overrun  <= 1'b0;
            r_clr_busy <= 1'b0;
            r_clr_skip <= 1'b0;
            r_clr_row  <= '0;
            r_clr_mask <= '0;
        end else begin
            r_blank_d <= blank;
            r_fstart  <= r_blank_d & ~blank;
            if (w_blank_rise && (r_state == SHIFT || r_state == INSERT)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (r_fstart) begin
                        if (w_div_wrap) begin
                            r_div   <= '0;
                            r_idx   <= '0;
                            r_state <= SHIFT;
                        end else begin
                            r_div   <= r_div + 4'd1;
                            r_state <= CLEAR;
                        end
                    end
                end
                SHIFT: begin
                    if (r_idx == CW'(ROWS)) begin
                        r_state <= INSERT;
                    end else begin
                        r_idx <= r_idx + CW'(1);
                    end
                end
                INSERT: begin
                    r_state <= CLEAR;
                end
                CLEAR: begin
                    if (r_clr_busy) begin
                        r_clr_busy <= 1'b0;
                        if (blank) begin
                            r_state <= IDLE;
                        end
                    end else if (blank) begin
                        r_state <= IDLE;
                    end else if (clr_valid) begin
                        r_clr_busy <= 1'b1;
                        r_clr_row  <= clr_row;
                        r_clr_mask <= clr_mask;
                        r_clr_skip <= ({1'b0, clr_row} >= CW'(ROWS));
                    end
                end
            endcase
        end
    end

`ifdef NOTE_MISS_OUT_EN
    logic               r_miss_valid;
    logic [ROW_W-1:0]   r_miss_row;

    always_ff @(posedge vgaclk or negedge reset_n) begin
        if (!reset_n) begin
            r_miss_valid <= 1'b0;
            r_miss_row   <= '0;
        end else begin
            r_miss_valid <= 1'b0;
            if (r_state == SHIFT && r_idx == CW'(1)) begin
                r_miss_valid <= 1'b1;
                r_miss_row   <= ram.ram_q;
            end
        end
    end

    assign miss_row   = r_miss_row;
    assign miss_valid = r_miss_valid;
`else
    assign miss_row   = '0;
    assign miss_valid = 1'b0;
`endif

    assign ram.ram_rdaddress = w_rdaddr;
    assign ram.ram_wraddress = w_wraddr;
    assign ram.ram_data      = w_wdata;
    assign ram.ram_wren      = w_wren;
    assign pix_q             = ram.ram_q;
    assign overrun           = r_overrun;

endmodule

// File: tb/tb_note_scroll_ctrl.sv
// Self-checking bench for note_scroll_ctrl: two instances (SPEED_DIV 1 and 3) on RAM models.
`timescale 1ns/1ps
module tb_note_scroll_ctrl;

    import note_pkg::*;

    localparam int NROWS = 20;
    localparam int NR    = 32;

    typedef struct {
        logic [4:0] row;
        row_t       pre;
        row_t       mask;
        row_t       exp;
    } clr_vec_t;

    logic       vgaclk = 1'b0;
    logic       reset_n = 1'b0;
    logic       blank = 1'b1;
    logic [4:0] pix_rdaddr = '0;
    row_t       chart_row = '0;
    logic       clr_valid = 1'b0;
    logic [4:0] clr_row = '0;
    row_t       clr_mask = '0;

    row_t pix_q0, pix_q1, miss_row0, miss_row1;
    logic chart_ack0, chart_ack1, clr_ready0, clr_ready1;
    logic miss_valid0, miss_valid1, overrun0, overrun1;

    note_scroll_ctrl_if #(.AW(5), .DW(ROW_W)) ram0 ();
    note_scroll_ctrl_if #(.AW(5), .DW(ROW_W)) ram1 ();

    row_t mem0 [NR];
    row_t mem1 [NR];
    row_t mdl  [NR];

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    int unsigned ack0 = 0, ack1 = 0, miss_cnt = 0, busy_cyc = 0;
    row_t        miss_last = '0;

    note_scroll_ctrl #(.ROWS(NROWS), .SPEED_DIV(1)) dut0 (
        .vgaclk(vgaclk), .reset_n(reset_n), .blank(blank), .pix_rdaddr(pix_rdaddr),
        .pix_q(pix_q0), .chart_row(chart_row), .chart_ack(chart_ack0),
        .clr_valid(clr_valid), .clr_row(clr_row), .clr_mask(clr_mask), .clr_ready(clr_ready0),
        .ram(ram0), .miss_row(miss_row0), .miss_valid(miss_valid0), .overrun(overrun0)
    );

    note_scroll_ctrl #(.ROWS(NROWS), .SPEED_DIV(3)) dut1 (
        .vgaclk(vgaclk), .reset_n(reset_n), .blank(blank), .pix_rdaddr(pix_rdaddr),
        .pix_q(pix_q1), .chart_row(chart_row), .chart_ack(chart_ack1),
        .clr_valid(clr_valid), .clr_row(clr_row), .clr_mask(clr_mask), .clr_ready(clr_ready1),
        .ram(ram1), .miss_row(miss_row1), .miss_valid(miss_valid1), .overrun(overrun1)
    );

    always #5 vgaclk = ~vgaclk;

    always @(posedge vgaclk) begin
        if (ram0.ram_wren) mem0[ram0.ram_wraddress] <= ram0.ram_data;
        ram0.ram_q <= mem0[ram0.ram_rdaddress];
        if (ram1.ram_wren) mem1[ram1.ram_wraddress] <= ram1.ram_data;
        ram1.ram_q <= mem1[ram1.ram_rdaddress];
    end

    always @(negedge vgaclk) begin
        if (chart_ack0) ack0++;
        if (chart_ack1) ack1++;
        if (miss_valid0) begin
            miss_cnt++;
            miss_last = miss_row0;
        end
        if (dut0.r_state == SHIFT || dut0.r_state == INSERT) busy_cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic row_t rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference: every visible row moves down one, chart row enters at the top.
    function automatic row_t model_scroll(input row_t top);
        row_t gone = mdl[NROWS-1];
        for (int r = NROWS - 1; r > 0; r--) mdl[r] = mdl[r-1];
        mdl[0] = top;
        return gone;
    endfunction

    function automatic void model_clear(input logic [4:0] row, input row_t mask);
        if (int'(row) < NROWS) mdl[row] = mdl[row] & ~mask;
    endfunction

    task automatic check_mem(input string nm);
        int unsigned idx = 0;
        for (int unsigned r = 0; r < NR; r++) begin
            if (mem0[r] !== mdl[r]) begin
                idx = r;
                break;
            end
        end
        chk($sformatf("%s row%0d", nm, idx), mem0[idx], mdl[idx]);
    endtask

    task automatic wait_ready(output int unsigned w);
        w = 0;
        do begin
            @(negedge vgaclk); #1;
            w++;
        end while (!clr_ready0 && w < 80);
    endtask

    task automatic do_clear(input logic [4:0] row, input row_t mask, input string nm);
        int unsigned w = 0;
        clr_valid = 1'b1;
        clr_row   = row;
        clr_mask  = mask;
        while (!clr_ready0 && w < 60) begin
            @(negedge vgaclk); #1;
            w++;
        end
        chk({nm, " accept"}, clr_ready0, 1'b1);
        @(negedge vgaclk); #1;
        clr_valid = 1'b0;
        chk({nm, " ready low in write"}, clr_ready0, 1'b0);
        @(negedge vgaclk); #1;
        model_clear(row, mask);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, " wren"}, ram0.ram_wren, 1'b0);
        chk({nm, " rdaddr"}, ram0.ram_rdaddress, 5'd0);
        chk({nm, " wraddr"}, ram0.ram_wraddress, 5'd0);
        chk({nm, " data"}, ram0.ram_data, '0);
        chk({nm, " chart_ack"}, chart_ack0, 1'b0);
        chk({nm, " clr_ready"}, clr_ready0, 1'b0);
        chk({nm, " miss_valid"}, miss_valid0, 1'b0);
        chk({nm, " miss_row"}, miss_row0, '0);
        chk({nm, " overrun"}, overrun0, 1'b0);
    endtask

    initial begin
        clr_vec_t    vecs [6];
        int unsigned w, a0, a1, frame;
        logic [4:0]  a;
        row_t        exp_miss;

        vecs[0] = '{5'd5,  128'hFF,   128'h0F, 128'hF0};
        vecs[1] = '{5'd0,  {128{1'b1}}, {64'h0, {64{1'b1}}}, {{64{1'b1}}, 64'h0}};
        vecs[2] = '{5'd19, 128'h123,  128'h1,  128'h122};
        vecs[3] = '{5'd20, 128'hDEAD, {128{1'b1}}, 128'hDEAD};
        vecs[4] = '{5'd31, 128'h55,   128'h55, 128'h55};
        vecs[5] = '{5'd7,  {1'b1, 126'h0, 1'b1}, {1'b1, 127'h0}, 128'h1};

        for (int unsigned r = 0; r < NR; r++) begin
            mem0[r] = ROW_W'(r);
            mem1[r] = ROW_W'(r);
            mdl[r]  = ROW_W'(r);
        end

        // reset values
        repeat (3) @(negedge vgaclk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (4) @(negedge vgaclk);
        #1;

        // basic scroll: 22 busy cycles, one ack, one miss of row 19
        chart_row = 128'hAA;
        ack0 = 0; ack1 = 0; miss_cnt = 0; busy_cyc = 0;
        blank = 1'b0;
        wait_ready(w);
        frame = 1;
        chk("frame1 latency to ready", w, 24);
        chk("frame1 busy cycles", busy_cyc, 22);
        chk("frame1 chart_ack count", ack0, 1);
        chk("div3 ack frame1", ack1, 0);
        exp_miss = model_scroll(chart_row);
`ifdef NOTE_MISS_OUT_EN
        chk("frame1 miss count", miss_cnt, 1);
        chk("frame1 miss row", miss_last, exp_miss);
`else
        chk("frame1 miss count", miss_cnt, 0);
        chk("frame1 miss row", miss_row0, '0);
`endif
        check_mem("frame1 scroll");

        // clear table during the same blanking
        for (int i = 0; i < 6; i++) begin
            mem0[vecs[i].row] = vecs[i].pre;
            mdl[vecs[i].row]  = vecs[i].pre;
            do_clear(vecs[i].row, vecs[i].mask, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d row value", i), mem0[vecs[i].row], vecs[i].exp);
            chk($sformatf("vec%0d ready again", i), clr_ready0, 1'b1);
        end
        check_mem("after table clears");

        // randomized frames against the model; SPEED_DIV=3 instance acks on frames 3 and 6
        for (int f = 0; f < 5; f++) begin
            blank = 1'b1;
            repeat (2) begin @(negedge vgaclk); #1; end
            for (int k = 0; k < 4; k++) begin
                a = 5'($urandom_range(0, 31));
                pix_rdaddr = a;
                @(negedge vgaclk); #1;
                chk($sformatf("pix_q addr%0d", a), pix_q0, mdl[a]);
            end
            pix_rdaddr = '0;
            chart_row = rand128();
            a0 = ack0; a1 = ack1;
            blank = 1'b0;
            wait_ready(w);
            frame++;
            chk($sformatf("frame%0d latency", frame), w, 24);
            chk($sformatf("frame%0d ack0", frame), ack0 - a0, 1);
            chk($sformatf("div3 ack frame%0d", frame), ack1 - a1, (frame % 3 == 0) ? 1 : 0);
            exp_miss = model_scroll(chart_row);
`ifdef NOTE_MISS_OUT_EN
            chk($sformatf("frame%0d miss row", frame), miss_last, exp_miss);
`endif
            for (int c = 0; c < int'($urandom_range(1, 3)); c++) begin
                do_clear(5'($urandom_range(0, 31)), rand128(), "rnd clear");
            end
            check_mem($sformatf("frame%0d", frame));
        end

        // clear held during active video: no accept, no write; accepted right after INSERT
        blank = 1'b1;
        repeat (2) begin @(negedge vgaclk); #1; end
        clr_valid = 1'b1;
        clr_row   = 5'd3;
        clr_mask  = {128{1'b1}};
        for (int k = 0; k < 6; k++) begin
            @(negedge vgaclk); #1;
            chk("active clr_ready", clr_ready0, 1'b0);
            chk("active wren", ram0.ram_wren, 1'b0);
        end
        chart_row = rand128();
        blank = 1'b0;
        wait_ready(w);
        chk("held clear accepted after INSERT", w, 24);
        @(negedge vgaclk); #1;
        clr_valid = 1'b0;
        @(negedge vgaclk); #1;
        void'(model_scroll(chart_row));
        model_clear(5'd3, {128{1'b1}});
        check_mem("held clear");

        // blank rises 5 cycles into SHIFT
        blank = 1'b1;
        repeat (3) begin @(negedge vgaclk); #1; end
        chart_row = rand128();
        a0 = ack0;
        blank = 1'b0;
        repeat (7) begin @(negedge vgaclk); #1; end
        blank = 1'b1;
        repeat (40) begin @(negedge vgaclk); #1; end
        chk("overrun set", overrun0, 1'b1);
        chk("overrun frame ack", ack0 - a0, 1);
        void'(model_scroll(chart_row));
        check_mem("overrun shift");
        chart_row = rand128();
        blank = 1'b0;
        wait_ready(w);
        chk("post-overrun latency", w, 24);
        void'(model_scroll(chart_row));
        check_mem("post-overrun shift");
        chk("overrun sticky", overrun0, 1'b1);

        // reset asserted mid-SHIFT
        blank = 1'b1;
        repeat (3) begin @(negedge vgaclk); #1; end
        chart_row = rand128();
        blank = 1'b0;
        repeat (6) begin @(negedge vgaclk); #1; end
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid-shift reset");
        for (int unsigned r = 0; r < NR; r++) mdl[r] = mem0[r];
        repeat (2) begin @(negedge vgaclk); #1; end
        reset_n = 1'b1;
        blank = 1'b1;
        repeat (3) begin @(negedge vgaclk); #1; end
        chart_row = rand128();
        a0 = ack0;
        blank = 1'b0;
        wait_ready(w);
        chk("after reset latency", w, 24);
        chk("after reset ack", ack0 - a0, 1);
        void'(model_scroll(chart_row));
        check_mem("after reset shift");
        chk("overrun cleared by reset", overrun0, 1'b0);

        blank = 1'b1;
        repeat (3) @(negedge vgaclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/note_scroll_ctrl.md
Name: note_scroll_ctrl

Overview:
- Sequences the 32x128 note RAM used by graphics: once per frame, during the blanking interval, it shifts every note row down by one and inserts the next chart row at the top.
- It then applies hit-clear requests from the button/scoring logic as read-modify-writes.
- During active video it hands the RAM read port to the pixel reader.
- Sits between the RAM and three requesters: the chart ROM feeder, the hit logic and the pixel path.

Parameters:
- ROWS, 20, number of visible note rows; RAM rows 0..ROWS-1, row 0 at top.
- ROW_W, 128, bits per row.
- ADDR_W, 5, RAM address width; requires ROWS <= 2**ADDR_W.
- SPEED_DIV, 1, scroll once every SPEED_DIV frames (1..15).

Ports:
- vgaclk  in  1  pixel clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- blank  in  1  0 = blanking interval, 1 = active video (same polarity as graphics).
- pix_rdaddr  in  ADDR_W  pixel-path read address.
- pix_q  out  ROW_W  RAM q passthrough to the pixel path.
- chart_row  in  ROW_W  next row to enter at the top.
- chart_ack  out  1  one-cycle pulse in the cycle chart_row is consumed.
- clr_valid  in  1  hit-clear request.
- clr_row  in  ADDR_W  row to clear.
- clr_mask  in  ROW_W  bits to clear.
- clr_ready  out  1  request accepted when clr_valid && clr_ready.
- ram_rdaddress  out  ADDR_W  to RAM.
- ram_wraddress  out  ADDR_W  to RAM.
- ram_data  out  ROW_W  to RAM.
- ram_wren  out  1  to RAM.
- ram_q  in  ROW_W  from RAM; valid 1 cycle after ram_rdaddress.
- miss_row  out  ROW_W  contents of the row leaving the bottom.
- miss_valid  out  1  one-cycle pulse qualifying miss_row.
- overrun  out  1  sticky flag, set when blank rises while the state is SHIFT or INSERT.

Behaviour:
- Reset values:
  - state = IDLE; frame divider = 0.
  - All RAM outputs 0, ram_wren = 0.
  - chart_ack, clr_ready, miss_valid, overrun = 0; miss_row = 0.
  - Reset mid-sequence abandons it; RAM contents are left untouched.
- Frame start: a registered falling edge of blank. The state leaves IDLE on the cycle after the edge is registered.
- IDLE:
  - ram_rdaddress = pix_rdaddr; ram_wren = 0.
  - On frame start, increment the divider. If divider == SPEED_DIV-1, clear it and go to SHIFT; otherwise go to CLEAR.
- SHIFT: counter r runs ROWS-1 down to 0, one read per cycle, with a pipelined write one cycle later.
  - Cycle i issues a read of row ROWS-1-i.
  - The next cycle writes the returned q to row (read row + 1).
  - The returned q of row ROWS-1 is not written; it drives miss_row with miss_valid = 1 for one cycle.
  - Takes ROWS+1 cycles including the drain cycle, then go to INSERT.
- INSERT (1 cycle): write chart_row to row 0, pulse chart_ack, go to CLEAR.
- CLEAR (only while blank == 0):
  - clr_ready = 1 in the accept cycle.
  - On handshake, capture clr_row and clr_mask and read the row. Next cycle write q & ~mask. Each clear costs 2 cycles; clr_ready = 0 in the write cycle.
  - clr_row >= ROWS: accepted, no write.
  - Clears address post-shift row positions.
  - When blank == 1, go to IDLE. A clear in progress always finishes its write first.
- Total scroll-frame cost is ROWS+2 cycles, far below the blanking length.
- If blank rises during SHIFT or INSERT: the sequence completes and keeps RAM ownership, overrun is set, and the pixel path reads whatever the RAM port is addressed to.
- pix_q = ram_q at all times; it is meaningful only in IDLE.
- A same-address read and write never occurs within one cycle.

Optional Feature:
- NOTE_MISS_OUT_EN defined: miss_row and miss_valid are driven as above.
- Undefined: miss_row = 0 and miss_valid = 0 constantly; the bottom-row read still occurs.

Decomposition:
- Package note_pkg holds:
  - ROW_W and ADDR_W constants.
  - Enum state_t {IDLE, SHIFT, INSERT, CLEAR}.
  - The typedef row_t as logic [ROW_W-1:0].
- No sub-module is needed; the frame-edge detector and divider stay inline.

Test Plan:
- Preload row r = r (r = 0..19), chart_row = 'hAA, one blank falling edge. Expect:
  - row r+1 = r for r = 0..18 and row 0 = 'hAA.
  - miss_row = 19 with a single miss_valid pulse.
  - A single chart_ack.
  - Exactly 22 cycles from the state leaving IDLE to the state entering CLEAR.
- SPEED_DIV = 3, 6 frames: the shift occurs on frames 3 and 6 only, and chart_ack pulses twice.
- During blanking, after the scroll, clear with row 5 = 'hFF, clr_row = 5, clr_mask = 'h0F. Expect row 5 = 'hF0, clr_ready low for one cycle, and each clear taking 2 cycles.
- clr_valid held during active video: clr_ready stays 0 and no write occurs. In the next blanking the clear is accepted after INSERT.
- blank rises 5 cycles into SHIFT: the shift completes correctly and overrun = 1 and stays set until reset_n.
- reset_n asserted mid-SHIFT: all outputs go to their reset values immediately. The next frame performs a normal shift.
